// File: rtl/divider.sv
// Iterative restoring shift-subtract divider for DIV/DIVU: quotient to lo, remainder to hi.
// Accept, then RUN (sign-prep slot plus one quotient bit per cycle), then FIX, then DONE.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             DivE,
  input  logic             SignedE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             completed,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    count_q, count_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             bneg_q, bneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             completed_q, completed_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   diff;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    count_d     = count_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    bneg_d      = bneg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    completed_d = completed_q;
    busy_d      = busy_q;
    diff        = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};

    case (state_q)
      IDLE: begin
        if (DivE) begin
          q_d     = SrcAE;
          d_d     = SrcBE;
          qneg_d  = SignedE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          rneg_d  = SignedE & SrcAE[WIDTH-1];
          bneg_d  = SignedE & SrcBE[WIDTH-1];
          r_d     = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Slot 0 takes the absolute values, keeping the negators off the accept path;
        // slots 1..WIDTH each retire one quotient bit.
        if (count_q == '0) begin
          q_d = rneg_q ? -q_q : q_q;
          d_d = bneg_q ? -d_q : d_q;
        end else if (!diff[WIDTH]) begin
          r_d = diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d        = qneg_q ? -q_q : q_q;
        hi_d        = rneg_q ? -r_q : r_q;
        completed_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        completed_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      bneg_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      completed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      count_q     <= count_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      bneg_q      <= bneg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      completed_q <= completed_d;
      busy_q      <= busy_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign completed = completed_q;
  assign busy      = busy_q;

endmodule
